iter_mult_hs: RTL and testbench
===============================

Name: iter_mult_hs

Overview:
- Parametrised iterative shift-add multiplier with a start/busy/done handshake and a runtime-selectable signed mode.
- Replaces the fixed unsigned iterative multiplier, which had no operand latching and whose finish flag depended on the testbench holding start high.
- Operands are captured on start and the 2*WIDTH-bit product is held stable until the next accepted start.
- Sits beside the ALU as the multi-cycle multiply unit for the datapath.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2. Product width is 2*WIDTH.
- CNTW, $clog2(WIDTH+1), width of the iteration counter. Derived; not for override.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  request; sampled on clk edge only in IDLE or DONE.
- signed_mode  input  1  1 = a and b are two's complement; 0 = unsigned. Latched with start.
- a  input  WIDTH  multiplicand; latched with start.
- b  input  WIDTH  multiplier; latched with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; product is valid from this cycle onward.
- product  output  2*WIDTH  result register; holds its value until the next accepted start completes.

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0; done=0; product=0; counter=0; internal operand/accumulator registers=0. Takes effect immediately, not at the next edge.
- States: IDLE, RUN, DONE. 2-bit encoding: IDLE=00, RUN=01, DONE=10.
- IDLE/DONE with start=1 at edge E0:
  - latch signed_mode; latch |a| and |b| as unsigned magnitudes (|x| taken only if signed_mode=1 and MSB=1; otherwise x as-is);
  - latch neg = signed_mode & (a[MSB] ^ b[MSB]);
  - accumulator={WIDTH zeros, |b|}; counter=WIDTH; state->RUN; done->0.
- Most-negative operand: |-2^(WIDTH-1)| = 2^(WIDTH-1). Fits in WIDTH unsigned bits; no special case needed.
- RUN, each edge:
  - addend = accum[0] ? |a| : 0;
  - {carry, sum} = accum_hi + addend (WIDTH+1 bits);
  - accum = {carry, sum, accum_lo[WIDTH-1:1]};
  - counter decrements by 1.
- Final iteration (counter==1 before the edge) at edge E_WIDTH: product = neg ? (~accum_next + 1) : accum_next, truncated to 2*WIDTH bits; state->DONE.
- DONE: done=1 for exactly one cycle. At the next edge, state->IDLE (or ->RUN if start=1), done->0.
- Latency: start accepted at E0 → done high during the cycle after edge E_WIDTH. That is WIDTH+1 edges from E0. Back-to-back throughput is one result per WIDTH+1 cycles.
- busy = (state==RUN). start while busy is ignored; operands, mode and counter are unaffected.
- product updates only at the final-iteration edge. It never shows partial sums.
- signed_mode=0 with operand MSBs set is a plain unsigned multiply. Result is exact in all cases; no overflow possible in 2*WIDTH bits.
- Reset mid-RUN: aborts immediately; done is never asserted for the aborted op; product=0.
- start and reset asserted together: reset wins.
- Inputs a, b and signed_mode may change freely after E0 without affecting the result.

Decomposition:
- Shared package iter_mult_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE;
  - 2-bit state typedef.
- One sub-module: iter_mult_dp.
  - Contents: magnitude/sign extraction, WIDTH+1-bit adder, 2*WIDTH accumulator shift register, final conditional negate.
  - Controlled by load/step/finish strobes from the FSM in iter_mult_hs.
- Counter and FSM stay in the top module.

Test Plan:
- Unsigned basic, WIDTH=4, signed_mode=0, a=12, b=12, start pulsed at E0 → busy high for 4 cycles; done pulses once after E4; product=8'd144 (0x90), stable afterwards.
- Signed mixed sign, WIDTH=4, a=4'b1101 (-3), b=4'd5 → product=8'hF1 (-15); a=5, b=-3 gives the same.
- Most-negative, WIDTH=4, signed: a=b=4'b1000 (-8) → product=8'h40 (64). a=-8, b=7 → 8'hC8 (-56). Unsigned a=b=15 → 8'hE1 (225).
- Protocol, WIDTH=8: start a=3, b=4. Then start with a=100, b=100 pulsed mid-RUN → ignored, product=16'd12. Then start in the DONE cycle with a=0, b=200 → accepted, next product=0, no idle gap.
- Reset mid-RUN, WIDTH=8: a=255, b=255 unsigned; reset asserted at cycle 3 of RUN, asynchronously between edges → busy, done and product go to 0 before the next edge; no done pulse. New start after release → 16'hFE01.
- Random sweep, WIDTH=8, 2000 ops, random signed_mode/a/b → product matches the reference model in both modes. done count equals the accepted-start count.

Source files
------------

// File: rtl/iter_mult_pkg.sv
// iter_mult_pkg: shared state encoding for the iterative multiplier
package iter_mult_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;
endpackage

// File: rtl/iter_mult_hs_if.sv
// iter_mult_hs_if: start/busy/done handshake and operand/product bus of the multiplier
interface iter_mult_hs_if #(parameter int WIDTH = 8);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  modport master (output start, signed_mode, a, b, input busy, done, product);
  modport slave  (input start, signed_mode, a, b, output busy, done, product);
endinterface

// File: rtl/iter_mult_dp.sv
// iter_mult_dp: magnitude capture, shift-add accumulation and signed fix-up of the product
module iter_mult_dp
  import iter_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);
  logic [WIDTH-1:0]   mag_a, abs_a, abs_b, addend;
  logic               neg;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH:0]     sum;
  // operands become unsigned magnitudes; the most-negative value still fits in WIDTH bits
  always_comb begin
    abs_a    = (signed_mode & a[WIDTH-1]) ? -a : a;
    abs_b    = (signed_mode & b[WIDTH-1]) ? -b : b;
    addend   = acc[0] ? mag_a : '0;
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    acc_next = {sum, acc[WIDTH-1:1]};
  end
  // load seeds the accumulator with |b|; each step consumes one multiplier bit; finish publishes the signed result
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mag_a   <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      product <= '0;
    end else begin
      if (load) begin
        mag_a <= abs_a;
        neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc   <= {{WIDTH{1'b0}}, abs_b};
      end else if (step) acc <= acc_next;
      if (finish) product <= neg ? -acc_next : acc_next;
    end
endmodule

// File: rtl/iter_mult_hs.sv
// iter_mult_hs: iterative shift-add multiplier with start/busy/done handshake and signed mode
module iter_mult_hs
  import iter_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  iter_mult_hs_if.slave bus
);
  localparam int CNTW = $clog2(WIDTH + 1);
  state_t          state;
  logic [CNTW-1:0] cnt;
  logic            load, step, finish;
  // a start is only honoured outside RUN; the last step is the one with one iteration left
  always_comb begin
    load   = bus.start & (state != ST_RUN);
    step   = state == ST_RUN;
    finish = step & (cnt == CNTW'(1));
  end
  // sequencer: IDLE/DONE accept a start, RUN counts WIDTH steps, DONE flags the result for one cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          cnt <= cnt - CNTW'(1);
          if (cnt == CNTW'(1)) begin
            state    <= ST_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        default: begin
          bus.done <= 1'b0;
          state    <= bus.start ? ST_RUN : ST_IDLE;
          bus.busy <= bus.start;
          if (bus.start) cnt <= CNTW'(WIDTH);
        end
      endcase
    end
  iter_mult_dp #(.WIDTH(WIDTH)) u_dp (
    .clk(clk),
    .reset(reset),
    .load(load),
    .step(step),
    .finish(finish),
    .signed_mode(bus.signed_mode),
    .a(bus.a),
    .b(bus.b),
    .product(bus.product)
  );
endmodule

// File: tb/tb_iter_mult_hs.sv
// tb_iter_mult_hs: directed and randomized checks of iter_mult_hs against a timing/arithmetic model
module tb_iter_mult_hs;
  localparam int W8 = 8;
  logic        clk = 1'b0;
  logic        reset4 = 1'b0;
  logic        reset8 = 1'b0;
  int          checks = 0;
  int          passes = 0;
  int          age = -1;
  logic [15:0] mprod = '0;
  logic [15:0] pend = '0;
  int          nacc = 0;
  int          ndone = 0;
  bit          cmp_en = 1'b0;

  iter_mult_hs_if #(.WIDTH(4)) if4();
  iter_mult_hs_if #(.WIDTH(8)) if8();
  iter_mult_hs #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset4), .bus(if4.slave));
  iter_mult_hs #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset8), .bus(if8.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] ref8(input logic sm, input logic [7:0] x, input logic [7:0] y);
    int p, q;
    p = sm ? int'($signed(x)) : int'(x);
    q = sm ? int'($signed(y)) : int'(y);
    return 16'(p * q);
  endfunction

  // model: age counts edges since an accepted start; busy for W8 cycles, then a one-cycle done
  initial forever begin
    @(posedge clk or posedge reset8);
    if (reset8) begin
      age   = -1;
      mprod = '0;
    end else if (age >= 0 && age < W8) begin
      age++;
      if (age == W8) mprod = pend;
    end else if (if8.start) begin
      pend = ref8(if8.signed_mode, if8.a, if8.b);
      age  = 0;
      nacc++;
    end else age = -1;
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("busy8", if8.busy, 64'(age >= 0 && age < W8));
      chk("done8", if8.done, 64'(age == W8));
      chk("product8", if8.product, mprod);
      if (if8.done) ndone++;
    end
  end

  task automatic run4(input logic sm, input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp);
    @(posedge clk); #1;
    if4.start = 1'b1; if4.signed_mode = sm; if4.a = x; if4.b = y;
    @(posedge clk); #1;
    if4.start = 1'b0; if4.a = 4'($urandom); if4.b = 4'($urandom); if4.signed_mode = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy4", if4.busy, 1);
      chk("done4_early", if4.done, 0);
    end
    @(negedge clk);
    chk("done4", if4.done, 1);
    chk("busy4_end", if4.busy, 0);
    chk("product4", if4.product, exp);
    @(negedge clk);
    chk("done4_pulse", if4.done, 0);
    chk("product4_hold", if4.product, exp);
  endtask

  task automatic start8(input logic sm, input logic [7:0] x, input logic [7:0] y);
    @(posedge clk); #1;
    if8.start = 1'b1; if8.signed_mode = sm; if8.a = x; if8.b = y;
    @(posedge clk); #1;
    if8.start = 1'b0;
  endtask

  task automatic wait_done8();
    for (int i = 0; i < 30 && if8.done !== 1'b1; i++) @(negedge clk);
    chk("done8_seen", if8.done, 1);
  endtask

  initial begin
    int cyc;
    if4.start = 0; if4.signed_mode = 0; if4.a = '0; if4.b = '0;
    if8.start = 0; if8.signed_mode = 0; if8.a = '0; if8.b = '0;
    #1 reset4 = 1'b1; reset8 = 1'b1;
    #1;
    chk("rst_busy4", if4.busy, 0);
    chk("rst_done4", if4.done, 0);
    chk("rst_product4", if4.product, 0);
    chk("rst_busy8", if8.busy, 0);
    chk("rst_done8", if8.done, 0);
    chk("rst_product8", if8.product, 0);
    repeat (2) @(posedge clk);
    #1 reset4 = 1'b0; reset8 = 1'b0; cmp_en = 1'b1;

    run4(0, 4'd12, 4'd12, 8'h90);
    run4(1, 4'b1101, 4'd5, 8'hF1);
    run4(1, 4'd5, 4'b1101, 8'hF1);
    run4(1, 4'b1000, 4'b1000, 8'h40);
    run4(1, 4'b1000, 4'd7, 8'hC8);
    run4(0, 4'd15, 4'd15, 8'hE1);

    start8(0, 8'd3, 8'd4);
    @(posedge clk); #1;
    if8.start = 1'b1; if8.a = 8'd100; if8.b = 8'd100;
    @(posedge clk); #1;
    if8.start = 1'b0;
    wait_done8();
    chk("proto_ignore", if8.product, 16'd12);
    if8.start = 1'b1; if8.signed_mode = 1'b0; if8.a = 8'd0; if8.b = 8'd200;
    @(posedge clk); #1;
    if8.start = 1'b0;
    @(negedge clk);
    chk("proto_nogap", if8.busy, 1);
    wait_done8();
    chk("proto_zero", if8.product, 16'd0);
    chk("model_pin", if8.product, ref8(0, 8'd0, 8'd200));

    start8(0, 8'd255, 8'd255);
    repeat (3) @(posedge clk);
    #3 reset8 = 1'b1;
    #1;
    chk("rst_async_busy", if8.busy, 0);
    chk("rst_async_done", if8.done, 0);
    chk("rst_async_product", if8.product, 0);
    repeat (2) @(posedge clk);
    #1 reset8 = 1'b0;
    start8(0, 8'd255, 8'd255);
    wait_done8();
    chk("rst_restart", if8.product, 16'hFE01);
    chk("model_pin_signed", ref8(1, 8'hFD, 8'd5), 16'hFFF1);

    @(posedge clk); #1;
    nacc = 0; ndone = 0; cyc = 0;
    while (nacc < 2000 && cyc < 60000) begin
      @(posedge clk); #1;
      if8.start       = ($urandom_range(0, 3) != 0);
      if8.signed_mode = 1'($urandom);
      if8.a           = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      if8.b           = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      cyc++;
    end
    if8.start = 1'b0;
    repeat (12) @(negedge clk);
    chk("sweep_budget", 64'(nacc >= 2000), 1);
    chk("done_count", ndone, nacc);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
